bpred_bht: RTL and testbench

BPRED_BHT -- requirements
Module: bpred_bht

---
 rtl/bpred_bht.sv | 118 +++++++++++
 tb/tb_bpred_bht.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/bpred_bht.sv
// bpred_bht: branch history table of 2^IDX_W two-bit saturating counters.
// Lookup is combinational on pc_f; updates go through a one-register stage
// and are written to the table on the following edge, with a bypass so a
// lookup sees the pending value. Define BPRED_STATS_EN to add the
// br_count / miss_count statistics counters.
module bpred_bht #(
   parameter int IDX_W = 6
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [63:0] pc_f,
   output logic        pred_taken,
   input  logic        upd_valid,
   input  logic [63:0] upd_pc,
   input  logic        upd_taken,
   input  logic        upd_pred,
   output logic        mispredict
`ifdef BPRED_STATS_EN
   ,
   output logic [31:0] br_count,
   output logic [31:0] miss_count
`endif
);

   localparam int DEPTH = 1 << IDX_W;

   // Two-bit saturating counter step: toward 11 when taken, toward 00 otherwise.
   function automatic logic [1:0] ctr_next(input logic [1:0] cur, input logic taken);
      if (taken) begin
         return (cur == 2'b11) ? 2'b11 : cur + 2'b01;
      end
      return (cur == 2'b00) ? 2'b00 : cur - 2'b01;
   endfunction

`ifdef BPRED_STATS_EN
   // 32-bit increment that sticks at all-ones instead of wrapping.
   function automatic logic [31:0] sat_inc32(input logic [31:0] cur);
      return (cur == 32'hFFFF_FFFF) ? cur : cur + 32'd1;
   endfunction
`endif

   logic [1:0]       bht_q [DEPTH];
   logic [IDX_W-1:0] idx_f;
   logic [IDX_W-1:0] idx_upd;
   logic             mis_set;
   logic             unused_pc_bits;

   logic             vld_p1;
   logic [IDX_W-1:0] wr_idx_p1;
   logic             wr_taken_p1;
   logic [1:0]       wr_next_p1;

   // Only the word-aligned low index bits select an entry; aliasing is accepted.
   assign idx_f          = pc_f[IDX_W+1:2];
   assign idx_upd        = upd_pc[IDX_W+1:2];
   assign unused_pc_bits = ^{pc_f[63:IDX_W+2], pc_f[1:0],
                             upd_pc[63:IDX_W+2], upd_pc[1:0]};

   assign mis_set = upd_valid & (upd_taken ^ upd_pred);

   // Next value is formed from the live table entry, so consecutive writes
   // to one index accumulate.
   assign wr_next_p1 = ctr_next(bht_q[wr_idx_p1], wr_taken_p1);

   // A pending write to the looked-up entry overrides the stored counter.
   assign pred_taken = (vld_p1 && (wr_idx_p1 == idx_f)) ? wr_next_p1[1]
                                                        : bht_q[idx_f][1];

   // ---- stage 0 -> stage 1: capture resolved branch ----
   // Update-stage valid and mispredict pulse, both cleared by reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p1     <= 1'b0;
         mispredict <= 1'b0;
      end else begin
         vld_p1     <= upd_valid;
         mispredict <= mis_set;
      end
   end

   // Update-stage payload; qualified by vld_p1 so it needs no reset.
   always_ff @(posedge clk) begin
      if (upd_valid) begin
         wr_idx_p1   <= idx_upd;
         wr_taken_p1 <= upd_taken;
      end
   end

   // ---- stage 1 -> table: commit counter ----
   // Counter table: weakly-not-taken after reset, one entry written per cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            bht_q[i] <= 2'b01;
         end
      end else if (vld_p1) begin
         bht_q[wr_idx_p1] <= wr_next_p1;
      end
   end

`ifdef BPRED_STATS_EN
   // Statistics: resolved branches and mispredictions, saturating.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         br_count   <= 32'd0;
         miss_count <= 32'd0;
      end else begin
         if (upd_valid) begin
            br_count <= sat_inc32(br_count);
         end
         if (mis_set) begin
            miss_count <= sat_inc32(miss_count);
         end
      end
   end
`endif

endmodule

// File: tb/tb_bpred_bht.sv
// tb_bpred_bht: directed and randomized stimulus for bpred_bht with a
// scoreboard. The driver keeps an abstract counter-per-index model in which
// an update takes effect for lookups in the cycle after it is presented, and
// queues the expected outputs; a monitor compares them against the DUT.
module tb_bpred_bht;

   localparam int IDX_W = 6;
   localparam int DEPTH = 1 << IDX_W;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [63:0] pc_f = 64'h1000;
   logic        pred_taken;
   logic        upd_valid = 1'b0;
   logic [63:0] upd_pc = 64'h0;
   logic        upd_taken = 1'b0;
   logic        upd_pred = 1'b0;
   logic        mispredict;
`ifdef BPRED_STATS_EN
   logic [31:0] br_count;
   logic [31:0] miss_count;
`endif

   bpred_bht #(.IDX_W(IDX_W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .pc_f       (pc_f),
      .pred_taken (pred_taken),
      .upd_valid  (upd_valid),
      .upd_pc     (upd_pc),
      .upd_taken  (upd_taken),
      .upd_pred   (upd_pred),
      .mispredict (mispredict)
`ifdef BPRED_STATS_EN
      ,
      .br_count   (br_count),
      .miss_count (miss_count)
`endif
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] id;
      logic        pred;
      logic        mis;
      logic [31:0] br;
      logic [31:0] miss;
   } exp_t;

   exp_t   sb[$];
   int     model [DEPTH];
   longint m_br;
   longint m_miss;
   int     next_id = 0;
   int     n_checks = 0;
   int     n_pass = 0;

   function automatic int pc_idx(input logic [63:0] pc);
      return int'(pc[IDX_W+1:2]);
   endfunction

   function automatic logic [63:0] rand_pc();
      logic [63:0] p;
      p = {$urandom, $urandom};
      if ($urandom_range(0, 3) != 0) p[IDX_W+1:2] = IDX_W'($urandom_range(0, 3));
      return p;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < DEPTH; i++) model[i] = 1;
      m_br   = 0;
      m_miss = 0;
   endtask

   task automatic check(input string name, input int id,
                        input logic [31:0] act, input logic [31:0] exp_v);
      n_checks++;
      if (act === exp_v) n_pass++;
      else $display("FAIL %s step %0d: got %0h expected %0h", name, id, act, exp_v);
   endtask

   task automatic push_exp(input logic mis);
      exp_t e;
      e.id   = next_id;
      e.pred = (model[pc_idx(pc_f)] >= 2);
      e.mis  = mis;
      e.br   = 32'(m_br);
      e.miss = 32'(m_miss);
      next_id++;
      sb.push_back(e);
   endtask

   // One clock: model the edge using the inputs held across it, then drive
   // the next inputs and queue what the DUT should show for them.
   task automatic step(input logic v, input logic [63:0] up, input logic t,
                       input logic p, input logic [63:0] pf);
      logic mis;
      int   c;
      @(posedge clk);
      mis = 1'b0;
      if (rst_n) begin
         mis = upd_valid & (upd_taken ^ upd_pred);
         if (upd_valid) begin
            c = model[pc_idx(upd_pc)] + (upd_taken ? 1 : -1);
            if (c > 3) c = 3;
            if (c < 0) c = 0;
            model[pc_idx(upd_pc)] = c;
            if (m_br < 64'hFFFF_FFFF) m_br++;
         end
         if (mis && m_miss < 64'hFFFF_FFFF) m_miss++;
      end
      #1;
      upd_valid = v;
      upd_pc    = up;
      upd_taken = t;
      upd_pred  = p;
      pc_f      = pf;
      push_exp(mis);
   endtask

   // Assert reset between edges, after the monitor's sample for this cycle.
   task automatic reset_mid();
      @(negedge clk);
      #2;
      model_reset();
      push_exp(1'b0);
      rst_n = 1'b0;
   endtask

   // Monitor: pop one expectation per output sample and compare.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk or negedge rst_n);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            check("pred_taken", int'(e.id), {31'd0, pred_taken}, {31'd0, e.pred});
            check("mispredict", int'(e.id), {31'd0, mispredict}, {31'd0, e.mis});
`ifdef BPRED_STATS_EN
            check("br_count", int'(e.id), br_count, e.br);
            check("miss_count", int'(e.id), miss_count, e.miss);
`endif
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic        v, t, p;
      logic [63:0] up, pf;
      model_reset();

      // Reset state, then release mid-cycle.
      step(1'b0, 64'h0, 1'b0, 1'b0, 64'h1000);
      step(1'b0, 64'h0, 1'b0, 1'b0, 64'h1000);
      #2 rst_n = 1'b1;

      // Two taken updates with upd_pred=0: 01 -> 10 -> 11, mispredict pulses.
      step(1'b1, 64'h1000, 1'b1, 1'b0, 64'h1000);
      step(1'b1, 64'h1000, 1'b1, 1'b0, 64'h1000);
      step(1'b0, 64'h0, 1'b0, 1'b0, 64'h1000);
      step(1'b0, 64'h0, 1'b0, 1'b0, 64'h1000);

      // Four not-taken: 11 -> 10 -> 01 -> 00 -> 00.
      repeat (4) step(1'b1, 64'h1000, 1'b0, 1'b1, 64'h1000);
      step(1'b0, 64'h0, 1'b0, 1'b0, 64'h1000);
      step(1'b0, 64'h0, 1'b0, 1'b0, 64'h1000);

      // Bring entry back to 01, then leave a taken write pending and reset.
      step(1'b1, 64'h1000, 1'b1, 1'b1, 64'h1000);
      step(1'b1, 64'h1000, 1'b1, 1'b0, 64'h1000);
      step(1'b0, 64'h0, 1'b0, 1'b0, 64'h1000);
      reset_mid();
      step(1'b0, 64'h0, 1'b0, 1'b0, 64'h1000);
      step(1'b0, 64'h0, 1'b0, 1'b0, 64'h1000);
      #2 rst_n = 1'b1;
      step(1'b0, 64'h0, 1'b0, 1'b0, 64'h1000);
      step(1'b0, 64'h0, 1'b0, 1'b0, 64'h1000);

      // Aliased PC 0x1100 shares index 0 with 0x1000; bypass shows it first.
      step(1'b1, 64'h1100, 1'b1, 1'b0, 64'h1000);
      step(1'b0, 64'h0, 1'b0, 1'b0, 64'h1000);
      step(1'b0, 64'h0, 1'b0, 1'b0, 64'h1000);

      // Randomized traffic over a few hot indices plus random aliases.
      for (int n = 0; n < 2000; n++) begin
         v  = ($urandom_range(0, 99) < 70);
         up = rand_pc();
         t  = 1'($urandom);
         p  = 1'($urandom);
         if ($urandom_range(0, 1) == 1) begin
            pf = rand_pc();
            pf[IDX_W+1:2] = up[IDX_W+1:2];
         end else begin
            pf = rand_pc();
         end
         step(v, up, t, p, pf);
      end

      step(1'b0, 64'h0, 1'b0, 1'b0, 64'h1000);
      step(1'b0, 64'h0, 1'b0, 1'b0, 64'h1000);
      @(negedge clk);
      #3;
      check("scoreboard_drained", 0, 32'(sb.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
